// File: rtl/snake_pkg.sv
// Shared constants and types for the snake food placer.
package snake_pkg;

    localparam int IDX_W_DEF  = 6;
    localparam int LFSR_W_DEF = 16;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [LFSR_W_DEF-1:0] LFSR_TAPS = 16'hB400;

    // An all-zero LFSR would lock up, so a zero seed loads this instead
    localparam logic [LFSR_W_DEF-1:0] SEED_NZ = 16'h0001;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_e;

endpackage

// File: rtl/snake_lfsr.sv
// Free-running Galois LFSR with synchronous reset to 1, seed load and zero-seed substitution.
module snake_lfsr
    import snake_pkg::*;
#(
    parameter int             W    = LFSR_W_DEF,
    parameter logic [W-1:0]   TAPS = W'(LFSR_TAPS)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    // Next state: shift right, fold the taps in when a one falls out
    always_comb begin
        state_d = {1'b0, state_q[W-1:1]};
        if (state_q[0]) begin
            state_d = state_d ^ TAPS;
        end else begin
            state_d = state_d;
        end
    end

    // State register: reset, load or advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= W'(SEED_NZ);
        end else if (load_i) begin
            state_q <= (seed_i == {W{1'b0}}) ? W'(SEED_NZ) : seed_i;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/snake_food_placer.sv
// Sequential food placer: probes one candidate cell per cycle until a free one is found or the grid is full.
// Define SNAKE_FOOD_STRIDE_EN for an odd pseudo-random stride instead of a linear scan.
module snake_food_placer
    import snake_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int N_OCC  = 8,
    parameter int LFSR_W = LFSR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     seed_we,
    input  logic [LFSR_W-1:0]        seed,
    input  logic                     req,
    input  logic [N_OCC*IDX_W-1:0]   occ_idx,
    input  logic [N_OCC-1:0]         occ_vld,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [IDX_W-1:0]         food_idx,
    output logic                     food_vld
);

    logic [LFSR_W-1:0] lfsr_s;
    logic [LFSR_W-1:0] src_s;
    logic [IDX_W-1:0]  base_s;
    logic [IDX_W-1:0]  step_s;
    logic [N_OCC-1:0]  hit_s;
    logic              coll_s;
    logic              unused_src_s;

    state_e            state_q;
    logic [IDX_W-1:0]  cand_q;
    logic [IDX_W-1:0]  step_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  food_idx_q;
    logic              food_vld_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;

    snake_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_W'(LFSR_TAPS))
    ) u_lfsr (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (seed_we),
        .seed_i  (seed),
        .state_o (lfsr_s)
    );

    // A seed written in the request cycle takes effect for that request
    assign src_s  = seed_we ? seed : lfsr_s;
    assign base_s = src_s[IDX_W-1:0];

`ifdef SNAKE_FOOD_STRIDE_EN
    assign step_s       = {src_s[2*IDX_W-1:IDX_W+1], 1'b1};
    assign unused_src_s = ^{src_s[LFSR_W-1:2*IDX_W], src_s[IDX_W]};
`else
    assign step_s       = {{(IDX_W-1){1'b0}}, 1'b1};
    assign unused_src_s = ^src_s[LFSR_W-1:IDX_W];
`endif

    for (genvar k = 0; k < N_OCC; k++) begin : g_hit
        assign hit_s[k] = occ_vld[k] && (occ_idx[k*IDX_W +: IDX_W] == cand_q);
    end
    assign coll_s = |hit_s;

    // Search FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_q     <= {IDX_W{1'b0}};
            step_q     <= {IDX_W{1'b0}};
            cnt_q      <= {IDX_W{1'b0}};
            food_idx_q <= {IDX_W{1'b0}};
            food_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        cand_q  <= base_s;
                        step_q  <= step_s;
                        cnt_q   <= {IDX_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= PROBE;
                    end
                end
                PROBE: begin
                    if (!coll_s) begin
                        food_idx_q <= cand_q;
                        food_vld_q <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (cnt_q == {IDX_W{1'b1}}) begin
                        // Odd step means every cell has now been probed once
                        food_vld_q <= 1'b0;
                        fail_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cand_q <= cand_q + step_q;
                        cnt_q  <= cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign food_idx = food_idx_q;
    assign food_vld = food_vld_q;

endmodule
